// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank between NumIn requesters, with response routing.
// Optional performance counters are built when TCDM_BANK_ARB_PERF_CNT_EN is defined.
module tcdm_bank_arbiter #(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned BeWidth      = DataWidth / 8,
    parameter int unsigned AddrMemWidth = 12,
    parameter int unsigned RespLat      = 1,
    parameter bit          WriteRespOn  = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumIn-1:0]                     req_i,
    input  logic [NumIn-1:0][AddrMemWidth-1:0]   add_i,
    input  logic [NumIn-1:0]                     wen_i,
    input  logic [NumIn-1:0][DataWidth-1:0]      wdata_i,
    input  logic [NumIn-1:0][BeWidth-1:0]        be_i,
    output logic [NumIn-1:0]                     gnt_o,
    output logic [NumIn-1:0]                     vld_o,
    output logic [NumIn-1:0][DataWidth-1:0]      rdata_o,
    output logic                                 req_o,
    input  logic                                 gnt_i,
    output logic [AddrMemWidth-1:0]              add_o,
    output logic                                 wen_o,
    output logic [DataWidth-1:0]                 wdata_o,
    output logic [BeWidth-1:0]                   be_o,
    input  logic [DataWidth-1:0]                 rdata_i
`ifdef TCDM_BANK_ARB_PERF_CNT_EN
    ,
    input  logic                                 perf_clr_i,
    output logic [31:0]                          conflict_cnt_o,
    output logic [31:0]                          stall_cnt_o
`endif
);

    localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] rr_next;
    logic [IdxW-1:0] winner;
    logic [31:0]     cand;
    logic            found;
    logic            transfer;
    logic            resp_new;

    logic            resp_vld_q [RespLat];
    logic [IdxW-1:0] resp_idx_q [RespLat];

    // Scan from the pointer upwards with wrap; the first asserted request wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            cand = 32'(rr_q) + i;
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            if (!found && req_i[cand[IdxW-1:0]]) begin
                winner = cand[IdxW-1:0];
                found  = 1'b1;
            end
        end
    end

    assign req_o    = |req_i;
    assign transfer = req_o & gnt_i;
    assign add_o    = req_o ? add_i[winner]   : '0;
    assign wen_o    = req_o ? wen_i[winner]   : 1'b0;
    assign wdata_o  = req_o ? wdata_i[winner] : '0;
    assign be_o     = req_o ? be_i[winner]    : '0;

    assign rr_next  = (winner == IdxW'(NumIn - 1)) ? '0 : winner + 1'b1;
    assign resp_new = transfer & (~wen_o | WriteRespOn);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (transfer) begin
            rr_q <= rr_next;
        end
    end

    // Response pipeline shifts every cycle; the bank has no backpressure on responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < RespLat; k++) begin
                resp_vld_q[k] <= 1'b0;
                resp_idx_q[k] <= '0;
            end
        end else begin
            resp_vld_q[0] <= resp_new;
            resp_idx_q[0] <= winner;
            for (int k = 1; k < RespLat; k++) begin
                resp_vld_q[k] <= resp_vld_q[k-1];
                resp_idx_q[k] <= resp_idx_q[k-1];
            end
        end
    end

    for (genvar gi = 0; gi < NumIn; gi++) begin : g_port
        logic sel;
        assign sel         = resp_vld_q[RespLat-1] && (resp_idx_q[RespLat-1] == IdxW'(gi));
        assign gnt_o[gi]   = transfer && (winner == IdxW'(gi));
        assign vld_o[gi]   = sel;
        assign rdata_o[gi] = sel ? rdata_i : '0;
    end

`ifdef TCDM_BANK_ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        conflict;
    logic        stall;

    assign conflict = ($countones(req_i) >= 2);
    assign stall    = req_o & ~gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else if (perf_clr_i) begin
            conflict_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Bench for tcdm_bank_arbiter: three configurations share one stimulus stream and are
// checked every cycle against a queue-free round-robin / delayed-response model.
module tb_tcdm_bank_arbiter;

    localparam int N    = 4;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         req_i;
    logic [N-1:0]         wen_i;
    logic [N-1:0][11:0]   add_i;
    logic [N-1:0][31:0]   wdata_i;
    logic [N-1:0][3:0]    be_i;
    logic                 gnt_i;
    logic [31:0]          rdata_i;

    logic [N-1:0]         gnt_o_d   [NDUT];
    logic [N-1:0]         vld_o_d   [NDUT];
    logic [N-1:0][31:0]   rdata_o_d [NDUT];
    logic                 req_o_d   [NDUT];
    logic [11:0]          add_o_d   [NDUT];
    logic                 wen_o_d   [NDUT];
    logic [31:0]          wdata_o_d [NDUT];
    logic [3:0]           be_o_d    [NDUT];
`ifdef TCDM_BANK_ARB_PERF_CNT_EN
    logic                 perf_clr;
    logic [31:0]          conflict_cnt_d [NDUT];
    logic [31:0]          stall_cnt_d    [NDUT];
`endif

    int n_vec = 0;
    int n_err = 0;

    // Config 0: RespLat=1, write responses. Config 1: RespLat=3, no write responses. Config 2: RespLat=2.
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        tcdm_bank_arbiter #(
            .NumIn(4), .DataWidth(32), .BeWidth(4), .AddrMemWidth(12),
            .RespLat((gi == 1) ? 3 : ((gi == 2) ? 2 : 1)),
            .WriteRespOn(gi != 1)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i),
            .gnt_o(gnt_o_d[gi]), .vld_o(vld_o_d[gi]), .rdata_o(rdata_o_d[gi]),
            .req_o(req_o_d[gi]), .gnt_i(gnt_i), .add_o(add_o_d[gi]), .wen_o(wen_o_d[gi]),
            .wdata_o(wdata_o_d[gi]), .be_o(be_o_d[gi]), .rdata_i(rdata_i)
`ifdef TCDM_BANK_ARB_PERF_CNT_EN
            ,
            .perf_clr_i(perf_clr), .conflict_cnt_o(conflict_cnt_d[gi]), .stall_cnt_o(stall_cnt_d[gi])
`endif
        );
    end

    function automatic int lat_of(input int d);
        return (d == 1) ? 3 : ((d == 2) ? 2 : 1);
    endfunction

    function automatic bit wr_of(input int d);
        return d != 1;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    int          m_rr = 0;
    int          cyc = 0;
    int          hist_port [8] = '{default: -1};
    bit          hist_wen  [8] = '{default: 1'b0};
`ifdef TCDM_BANK_ARB_PERF_CNT_EN
    logic [31:0] m_conf = '0;
    logic [31:0] m_stall = '0;
`endif

    always @(negedge clk) begin
        int               w;
        int               s;
        logic             xfer;
        logic [N-1:0]     e_gnt;
        logic [N-1:0]     e_vld;
        logic [N-1:0][31:0] e_rdata;
        logic [11:0]      e_add;
        logic             e_wen;
        logic [31:0]      e_wdata;
        logic [3:0]       e_be;

        if (!rst_n) begin
            m_rr = 0;
            for (int i = 0; i < 8; i++) hist_port[i] = -1;
`ifdef TCDM_BANK_ARB_PERF_CNT_EN
            m_conf  = '0;
            m_stall = '0;
`endif
        end

        w       = pick(req_i, m_rr);
        xfer    = (w >= 0) && gnt_i;
        e_gnt   = xfer ? (4'b0001 << w) : 4'b0000;
        e_add   = (w >= 0) ? add_i[w]   : 12'h0;
        e_wen   = (w >= 0) ? wen_i[w]   : 1'b0;
        e_wdata = (w >= 0) ? wdata_i[w] : 32'h0;
        e_be    = (w >= 0) ? be_i[w]    : 4'h0;

        for (int d = 0; d < NDUT; d++) begin
            e_vld   = '0;
            e_rdata = '0;
            s = (((cyc - lat_of(d)) % 8) + 8) % 8;
            if (rst_n && hist_port[s] >= 0 && (!hist_wen[s] || wr_of(d))) begin
                e_vld[hist_port[s]]   = 1'b1;
                e_rdata[hist_port[s]] = rdata_i;
            end
            chk($sformatf("d%0d req_o", d),   req_o_d[d],   |req_i);
            chk($sformatf("d%0d gnt_o", d),   gnt_o_d[d],   e_gnt);
            chk($sformatf("d%0d add_o", d),   add_o_d[d],   e_add);
            chk($sformatf("d%0d wen_o", d),   wen_o_d[d],   e_wen);
            chk($sformatf("d%0d wdata_o", d), wdata_o_d[d], e_wdata);
            chk($sformatf("d%0d be_o", d),    be_o_d[d],    e_be);
            chk($sformatf("d%0d vld_o", d),   vld_o_d[d],   e_vld);
            chk($sformatf("d%0d rdata_o", d), rdata_o_d[d], e_rdata);
`ifdef TCDM_BANK_ARB_PERF_CNT_EN
            chk($sformatf("d%0d conflict_cnt", d), conflict_cnt_d[d], m_conf);
            chk($sformatf("d%0d stall_cnt", d),    stall_cnt_d[d],    m_stall);
`endif
        end

        s = cyc % 8;
        hist_port[s] = -1;
        if (rst_n) begin
            if (xfer) begin
                hist_port[s] = w;
                hist_wen[s]  = wen_i[w];
                m_rr = (w + 1) % N;
                $display("xfer cyc=%0d port=%0d %s add=%03h", cyc, w, wen_i[w] ? "st" : "ld", add_i[w]);
            end
`ifdef TCDM_BANK_ARB_PERF_CNT_EN
            if (perf_clr) begin
                m_conf  = '0;
                m_stall = '0;
            end else begin
                if ($countones(req_i) >= 2 && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 1;
                if ((|req_i) && !gnt_i && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            end
`endif
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] w, input logic g);
        @(posedge clk);
        #1;
        req_i = r;
        wen_i = w;
        gnt_i = g;
        for (int p = 0; p < N; p++) begin
            add_i[p]   = 12'($urandom);
            wdata_i[p] = $urandom;
            be_i[p]    = 4'($urandom);
        end
        rdata_i = $urandom;
    endtask

    initial begin
        int seqp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [N-1:0] exp_v;

        req_i = '0; wen_i = '0; add_i = '0; wdata_i = '0; be_i = '0; gnt_i = 1'b0; rdata_i = '0;
`ifdef TCDM_BANK_ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: everything zero.
        for (int k = 0; k < 5; k++) begin
            step(4'b0000, 4'b0000, 1'b1);
            #2;
            for (int d = 0; d < NDUT; d++) begin
                chk("idle req_o", req_o_d[d], 1'b0);
                chk("idle gnt_o", gnt_o_d[d], 4'b0000);
                chk("idle vld_o", vld_o_d[d], 4'b0000);
                chk("idle rdata_o", rdata_o_d[d], 128'h0);
            end
        end

        // All four loading, bank always ready: strict rotation, responses one cycle later.
        for (int k = 0; k < 9; k++) begin
            step((k < 8) ? 4'b1111 : 4'b0000, 4'b0000, 1'b1);
            #2;
            if (k < 8) chk("rot gnt_o", gnt_o_d[0], 4'b0001 << seqp[k]);
            exp_v = (k > 0) ? (4'b0001 << seqp[k-1]) : 4'b0000;
            chk("rot vld_o", vld_o_d[0], exp_v);
            if (k > 0) chk("rot rdata_o", rdata_o_d[0][seqp[k-1]], rdata_i);
        end

        // Stalled bank: pointer must not move.
        for (int k = 0; k < 3; k++) begin
            step(4'b0101, 4'b0000, 1'b0);
            #2;
            chk("stall gnt_o", gnt_o_d[0], 4'b0000);
            chk("stall req_o", req_o_d[0], 1'b1);
        end
        step(4'b0101, 4'b0000, 1'b1);
        #2 chk("unstall gnt_o first", gnt_o_d[0], 4'b0001);
        step(4'b0101, 4'b0000, 1'b1);
        #2 chk("unstall gnt_o second", gnt_o_d[0], 4'b0100);

        // RespLat=3 routing: port1 at t, port3 at t+1.
        repeat (3) step(4'b0000, 4'b0000, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        #2 chk("lat3 gnt t", gnt_o_d[1], 4'b0010);
        step(4'b1000, 4'b0000, 1'b1);
        #2 chk("lat3 gnt t+1", gnt_o_d[1], 4'b1000);
        for (int j = 2; j <= 5; j++) begin
            step(4'b0000, 4'b0000, 1'b1);
            #2;
            exp_v = (j == 3) ? 4'b0010 : ((j == 4) ? 4'b1000 : 4'b0000);
            chk("lat3 vld_o", vld_o_d[1], exp_v);
            if (j == 3) chk("lat3 rdata_o", rdata_o_d[1][1], rdata_i);
        end

        // Store on port 2: forwarded fields; no response where write responses are off.
        step(4'b0100, 4'b0100, 1'b1);
        add_i[2] = 12'h0A5;
        wdata_i[2] = 32'hDEAD_BEEF;
        be_i[2] = 4'hF;
        #2;
        chk("st add_o", add_o_d[1], 12'h0A5);
        chk("st wen_o", wen_o_d[1], 1'b1);
        chk("st wdata_o", wdata_o_d[1], 32'hDEAD_BEEF);
        chk("st be_o", be_o_d[1], 4'hF);
        chk("st gnt_o", gnt_o_d[1], 4'b0100);
        for (int j = 1; j <= 5; j++) begin
            step(4'b0000, 4'b0000, 1'b1);
            #2;
            chk("st no vld_o", vld_o_d[1], 4'b0000);
            if (j == 1) chk("st wresp vld_o", vld_o_d[0], 4'b0100);
        end

`ifdef TCDM_BANK_ARB_PERF_CNT_EN
        step(4'b0000, 4'b0000, 1'b1);
        perf_clr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(4'b0011, 4'b0000, 1'b0);
            perf_clr = 1'b0;
        end
        step(4'b0000, 4'b0000, 1'b1);
        perf_clr = 1'b1;
        #2;
        chk("perf conflict=10", conflict_cnt_d[0], 32'd10);
        chk("perf stall=10", stall_cnt_d[0], 32'd10);
        step(4'b0000, 4'b0000, 1'b1);
        perf_clr = 1'b0;
        #2;
        chk("perf conflict clr", conflict_cnt_d[0], 32'd0);
        chk("perf stall clr", stall_cnt_d[0], 32'd0);
`endif

        // Reset with two loads in flight on the RespLat=2 config.
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 4'b0000, 1'b1);
            #2 chk("rst no vld_o", vld_o_d[2], 4'b0000);
        end
        step(4'b1111, 4'b0000, 1'b1);
        #2 chk("rst ptr gnt_o", gnt_o_d[2], 4'b0001);

        // Randomized traffic with occasional resets and counter clears.
        for (int k = 0; k < 1500; k++) begin
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
            rst_n = ($urandom_range(0, 199) != 0);
`ifdef TCDM_BANK_ARB_PERF_CNT_EN
            perf_clr = ($urandom_range(0, 49) == 0);
`endif
        end
        rst_n = 1'b1;
        repeat (5) step(4'b0000, 4'b0000, 1'b1);
        @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
